// File: rtl/avl_timer_pkg.sv
// Shared register map, bit positions and CTRL layout for the avl_timer slave.
package avl_timer_pkg;

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_RELOAD = 2'd2;
    localparam logic [1:0] ADDR_COUNT  = 2'd3;

    localparam int CTRL_RUN     = 0;
    localparam int CTRL_IRQ_EN  = 1;
    localparam int CTRL_ONESHOT = 2;

    localparam int STATUS_PEND = 0;
    localparam int STATUS_RUN  = 1;

    // Field order puts run at bit 0 so the struct maps straight onto CTRL[2:0].
    typedef struct packed {
        logic oneshot;
        logic irq_en;
        logic run;
    } ctrl_t;

endpackage

// File: rtl/avl_timer_prescaler.sv
// Free-running clk divider for avl_timer: emits one tick every PRESCALE cycles while run is high.
module timer_prescaler #(
    parameter int PRESCALE = 50
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic restart,
    output logic tick
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] cnt;

    assign tick = run && (cnt == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (!run || restart || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/avl_timer.sv
// Avalon-MM down-counting interval timer with level interrupt.
// Optional one-shot mode is built when AVL_TIMER_ONESHOT_EN is defined.
module avl_timer
    import avl_timer_pkg::*;
#(
    parameter int          PRESCALE     = 50,
    parameter logic [31:0] RESET_RELOAD = 32'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  avl_address,
    input  logic        avl_read,
    input  logic        avl_write,
    input  logic [31:0] avl_writedata,
    output logic [31:0] avl_readdata,
    output logic        avl_irq
);

    ctrl_t       ctrl;
    logic        pend;
    logic [31:0] reload;
    logic [31:0] count;

    logic wr_ctrl;
    logic wr_status;
    logic wr_reload;
    logic wr_count;
    logic restart;
    logic tick;
    logic expiry;
    logic unused_rd;

    // Reads are side-effect free, so the strobe carries no information here.
    assign unused_rd = avl_read;

    assign wr_ctrl   = avl_write && (avl_address == ADDR_CTRL);
    assign wr_status = avl_write && (avl_address == ADDR_STATUS);
    assign wr_reload = avl_write && (avl_address == ADDR_RELOAD);
    assign wr_count  = avl_write && (avl_address == ADDR_COUNT);

    assign restart = wr_ctrl && !ctrl.run && avl_writedata[CTRL_RUN];

    // A software COUNT write in the tick cycle overrides both decrement and expiry.
    assign expiry = tick && !wr_count && (count == 32'd0);

    timer_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk     (clk),
        .rst     (rst),
        .run     (ctrl.run),
        .restart (restart),
        .tick    (tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl <= '0;
        end else if (wr_ctrl) begin
            ctrl.run    <= avl_writedata[CTRL_RUN];
            ctrl.irq_en <= avl_writedata[CTRL_IRQ_EN];
`ifdef AVL_TIMER_ONESHOT_EN
            ctrl.oneshot <= avl_writedata[CTRL_ONESHOT];
`else
            ctrl.oneshot <= 1'b0;
`endif
        end
`ifdef AVL_TIMER_ONESHOT_EN
        else if (expiry && ctrl.oneshot) begin
            ctrl.run <= 1'b0;
        end
`endif
    end

    // Set beats clear so an expiry coinciding with a W1C is never dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend <= 1'b0;
        end else if (expiry) begin
            pend <= 1'b1;
        end else if (wr_status && avl_writedata[STATUS_PEND]) begin
            pend <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reload <= RESET_RELOAD;
        end else if (wr_reload) begin
            reload <= avl_writedata;
        end
    end

    // Zero reloads instead of decrementing, so the counter never underflows.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= 32'd0;
        end else if (wr_count) begin
            count <= avl_writedata;
        end else if (expiry) begin
            count <= reload;
        end else if (tick) begin
            count <= count - 32'd1;
        end
    end

    always_comb begin
        avl_readdata = 32'd0;
        case (avl_address)
            ADDR_CTRL:   avl_readdata[2:0] = ctrl;
            ADDR_STATUS: begin
                avl_readdata[STATUS_PEND] = pend;
                avl_readdata[STATUS_RUN]  = ctrl.run;
            end
            ADDR_RELOAD: avl_readdata = reload;
            ADDR_COUNT:  avl_readdata = count;
            default:     avl_readdata = 32'd0;
        endcase
    end

    assign avl_irq = pend && ctrl.irq_en;

endmodule

// File: tb/tb_avl_timer.sv
// Scoreboard bench for avl_timer with PRESCALE=4; expectations are queued then popped on sampling.
`timescale 1ns/1ps
module tb_avl_timer;

    localparam logic [1:0] A_CTRL   = 2'd0;
    localparam logic [1:0] A_STATUS = 2'd1;
    localparam logic [1:0] A_RELOAD = 2'd2;
    localparam logic [1:0] A_COUNT  = 2'd3;

`ifdef AVL_TIMER_ONESHOT_EN
    localparam bit OS = 1'b1;
`else
    localparam bit OS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  avl_address = 2'd0;
    logic        avl_read = 1'b0;
    logic        avl_write = 1'b0;
    logic [31:0] avl_writedata = 32'd0;
    logic [31:0] avl_readdata;
    logic        avl_irq;

    int cyc = 0;
    int n_vec = 0;
    int n_err = 0;
    int t0, t1, t2;

    logic [31:0] exp_q[$];
    string       tag_q[$];

    avl_timer #(
        .PRESCALE     (4),
        .RESET_RELOAD (32'd0)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .avl_address   (avl_address),
        .avl_read      (avl_read),
        .avl_write     (avl_write),
        .avl_writedata (avl_writedata),
        .avl_readdata  (avl_readdata),
        .avl_irq       (avl_irq)
    );

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach the end, cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cyc %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic pop_cmp(input logic [31:0] obs);
        if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL scoreboard_empty: got 0x%08h with no expectation", obs);
        end else begin
            check(tag_q.pop_front(), obs, exp_q.pop_front());
        end
    endtask

    task automatic expect_rd(input logic [1:0] a, input logic [31:0] e, input string tag);
        exp_q.push_back(e);
        tag_q.push_back(tag);
        avl_address = a;
        avl_read    = 1'b1;
        #1;
        pop_cmp(avl_readdata);
        avl_read = 1'b0;
    endtask

    task automatic expect_irq(input logic e, input string tag);
        exp_q.push_back({31'd0, e});
        tag_q.push_back(tag);
        #1;
        pop_cmp({31'd0, avl_irq});
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        avl_address   = a;
        avl_writedata = d;
        avl_write     = 1'b1;
        @(negedge clk);
        avl_write = 1'b0;
    endtask

    // Issue a write so that it is captured exactly on posedge number n.
    task automatic wr_at(input int n, input logic [1:0] a, input logic [31:0] d);
        if (cyc > n - 2) begin
            n_err++;
            $display("FAIL wr_at_late: cyc %0d already past slot for edge %0d", cyc, n);
        end
        while (cyc < n - 2) @(negedge clk);
        wr(a, d);
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        expect_rd(A_CTRL,   32'd0, "rst_ctrl");
        expect_rd(A_STATUS, 32'd0, "rst_status");
        expect_rd(A_RELOAD, 32'd0, "rst_reload");
        expect_rd(A_COUNT,  32'd0, "rst_count");
        expect_irq(1'b0, "rst_irq");

        // periodic run, RELOAD=3: expiry 16 cycles after the RUN write
        wr(A_RELOAD, 32'd3);
        wr(A_COUNT,  32'd3);
        wr(A_CTRL,   32'd3);
        t0 = cyc;
        wait_cyc(t0 + 15);
        expect_irq(1'b0, "irq_before_expiry");
        expect_rd(A_COUNT, 32'd0, "count_before_expiry");
        wait_cyc(t0 + 16);
        expect_irq(1'b1, "irq_after_expiry");
        expect_rd(A_STATUS, 32'd3, "status_after_expiry");
        expect_rd(A_COUNT,  32'd3, "count_reloaded");

        // W1C, then W1C colliding with the next expiry
        wr(A_STATUS, 32'd1);
        expect_irq(1'b0, "irq_after_w1c");
        expect_rd(A_STATUS, 32'd2, "status_after_w1c");
        wr_at(t0 + 32, A_STATUS, 32'd1);
        expect_rd(A_STATUS, 32'd3, "w1c_vs_expiry_pend");
        expect_irq(1'b1, "w1c_vs_expiry_irq");

        // IRQ_EN=0 across an expiry, then enable
        wr(A_STATUS, 32'd1);
        wr(A_CTRL,   32'd1);
        expect_rd(A_STATUS, 32'd2, "masked_pre_status");
        wait_cyc(t0 + 48);
        expect_rd(A_STATUS, 32'd3, "masked_pend");
        expect_irq(1'b0, "masked_irq");
        wr(A_CTRL, 32'd3);
        expect_irq(1'b1, "unmasked_irq");

        // COUNT write on the tick that would have expired
        wr(A_STATUS, 32'd1);
        wr_at(t0 + 64, A_COUNT, 32'd10);
        expect_rd(A_COUNT,  32'd10, "count_write_wins");
        expect_rd(A_STATUS, 32'd2,  "count_write_no_expiry");
        expect_irq(1'b0, "count_write_irq");
        wait_cyc(t0 + 68);
        expect_rd(A_COUNT, 32'd9, "count_after_write_tick");

        // reset mid-count with COUNT=2 and PEND=1
        wr(A_COUNT, 32'd0);
        wait_cyc(t0 + 76);
        expect_rd(A_STATUS, 32'd3, "pre_rst_status");
        expect_rd(A_COUNT,  32'd2, "pre_rst_count");
        rst = 1'b1;
        expect_irq(1'b0, "rst_async_irq");
        expect_rd(A_CTRL,   32'd0, "rst_async_ctrl");
        expect_rd(A_STATUS, 32'd0, "rst_async_status");
        expect_rd(A_RELOAD, 32'd0, "rst_async_reload");
        expect_rd(A_COUNT,  32'd0, "rst_async_count");
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        expect_rd(A_COUNT,  32'd0, "stopped_count");
        expect_rd(A_STATUS, 32'd0, "stopped_status");

        // restart from 0xFFFFFFFF: modulo decrement
        wr(A_COUNT, 32'hFFFF_FFFF);
        wr(A_CTRL,  32'd1);
        t1 = cyc;
        wait_cyc(t1 + 3);
        expect_rd(A_COUNT, 32'hFFFF_FFFF, "wrap_before_tick");
        wait_cyc(t1 + 4);
        expect_rd(A_COUNT,  32'hFFFF_FFFE, "wrap_decrement");
        expect_rd(A_STATUS, 32'd2, "wrap_no_pend");

        // one-shot (or periodic fallback) with RELOAD=1
        wr(A_CTRL,   32'd0);
        wr(A_COUNT,  32'd1);
        wr(A_RELOAD, 32'd1);
        wr(A_STATUS, 32'd1);
        wr(A_CTRL,   32'd7);
        t2 = cyc;
        expect_rd(A_CTRL, OS ? 32'd7 : 32'd3, "ctrl_after_7");
        wait_cyc(t2 + 8);
        expect_rd(A_STATUS, OS ? 32'd1 : 32'd3, "os_first_expiry");
        wait_cyc(t2 + 20);
        expect_rd(A_CTRL,   OS ? 32'd6 : 32'd3, "os_ctrl_late");
        expect_rd(A_COUNT,  OS ? 32'd1 : 32'd0, "os_count_late");
        wr(A_STATUS, 32'd1);
        wait_cyc(t2 + 32);
        expect_rd(A_STATUS, OS ? 32'd0 : 32'd3, "os_no_second_expiry");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
